// File: rtl/armleocpu_prefetch.sv
// Instruction prefetch unit: keeps a DEPTH-entry queue of fetched words ahead of execute.
// Define ARMLEOCPU_PREFETCH_PERF_EN to add the perf_fetched / perf_killed counters.
module armleocpu_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_2000,
    parameter int          DEPTH        = 4,
    parameter int          CAUSE_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c_reset_done,
    output logic [3:0]         c_cmd,
    output logic [31:0]        c_address,
    input  logic [3:0]         c_response,
    input  logic [31:0]        c_load_data,
    input  logic               redir_valid,
    input  logic [31:0]        redir_pc,
    output logic               f2e_valid,
    input  logic               f2e_ready,
    output logic [31:0]        f2e_instr,
    output logic [31:0]        f2e_pc,
    output logic               f2e_err,
    output logic [CAUSE_W-1:0] f2e_cause,
    input  logic               dbg_request,
    input  logic               dbg_set_pc,
    input  logic [31:0]        dbg_pc,
    input  logic               dbg_exit_request,
    output logic               dbg_mode,
    output logic               dbg_done
`ifdef ARMLEOCPU_PREFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_killed
`endif
);

    localparam logic [3:0] CACHE_CMD_NONE            = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE         = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE       = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT  = 4'd5;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_WAIT_CACHE,
        ST_RUN,
        ST_FAULT_STALL,
        ST_HALT_DRAIN,
        ST_HALT
    } state_t;

    state_t state, state_next;

    logic [31:0]        fetch_pc;
    logic               outstanding;
    logic               kill;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [PTR_W:0]     count;

    logic [31:0]        pc_q    [DEPTH];
    logic [31:0]        instr_q [DEPTH];
    logic               err_q   [DEPTH];
    logic [CAUSE_W-1:0] cause_q [DEPTH];

    logic resp_done, resp_fault, resp_end;
    logic issue, push, push_fault, drop, clear, pop;
    logic load_redir, load_dbg, done_pulse, set_kill;
    logic [CAUSE_W-1:0] push_cause;

    assign resp_done  = (c_response == CACHE_RESPONSE_DONE);
    assign resp_fault = (c_response == CACHE_RESPONSE_ACCESSFAULT) ||
                        (c_response == CACHE_RESPONSE_MISSALIGNED) ||
                        (c_response == CACHE_RESPONSE_PAGEFAULT);
    assign resp_end   = outstanding && (resp_done || resp_fault);

    assign push_cause = (c_response == CACHE_RESPONSE_ACCESSFAULT) ? CAUSE_W'(1)  :
                        (c_response == CACHE_RESPONSE_PAGEFAULT)   ? CAUSE_W'(12) :
                        '0;

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        push_fault = 1'b0;
        drop       = 1'b0;
        clear      = 1'b0;
        load_redir = 1'b0;
        load_dbg   = 1'b0;
        done_pulse = 1'b0;
        set_kill   = 1'b0;
        unique case (state)
            ST_WAIT_CACHE: begin
                if (c_reset_done) state_next = ST_RUN;
            end
            ST_RUN, ST_FAULT_STALL, ST_HALT_DRAIN: begin
                if (redir_valid) begin
                    // A response landing in the redirect cycle belongs to the old stream.
                    clear      = 1'b1;
                    load_redir = 1'b1;
                    if (resp_end) drop = 1'b1;
                    else if (outstanding) set_kill = 1'b1;
                    if (state == ST_FAULT_STALL) state_next = ST_RUN;
                end else begin
                    if (resp_end) begin
                        if (kill || state == ST_HALT_DRAIN) begin
                            drop = 1'b1;
                        end else begin
                            push = 1'b1;
                            if (!resp_done) begin
                                push_fault = 1'b1;
                                state_next = ST_FAULT_STALL;
                            end
                        end
                    end
                    if (state == ST_RUN) issue = !outstanding && (count < FULL);
                    if (state != ST_HALT_DRAIN && dbg_request) state_next = ST_HALT_DRAIN;
                    if (state == ST_HALT_DRAIN && !outstanding) begin
                        clear      = 1'b1;
                        done_pulse = 1'b1;
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (dbg_set_pc) begin
                    load_dbg   = 1'b1;
                    done_pulse = 1'b1;
                end
                if (dbg_exit_request) state_next = ST_RUN;
            end
            default: state_next = ST_WAIT_CACHE;
        endcase
    end

    assign pop = f2e_valid && f2e_ready && !clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_WAIT_CACHE;
            fetch_pc    <= RESET_VECTOR;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            dbg_done    <= 1'b0;
        end else begin
            state    <= state_next;
            dbg_done <= done_pulse;

            if (issue) outstanding <= 1'b1;
            else if (push || drop) outstanding <= 1'b0;

            if (push || drop) kill <= 1'b0;
            else if (set_kill) kill <= 1'b1;

            if (load_redir) fetch_pc <= redir_pc;
            else if (load_dbg) fetch_pc <= dbg_pc;
            else if (push && !push_fault) fetch_pc <= fetch_pc + 32'd4;

            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_q[wr_ptr]    <= fetch_pc;
            instr_q[wr_ptr] <= push_fault ? NOP : c_load_data;
            err_q[wr_ptr]   <= push_fault;
            cause_q[wr_ptr] <= push_fault ? push_cause : '0;
        end
    end

    assign f2e_valid = (count != '0);
    assign f2e_pc    = pc_q[rd_ptr];
    assign f2e_instr = instr_q[rd_ptr];
    assign f2e_err   = f2e_valid && err_q[rd_ptr];
    assign f2e_cause = cause_q[rd_ptr];
    assign dbg_mode  = (state == ST_HALT);
    assign c_cmd     = issue ? CACHE_CMD_EXECUTE : CACHE_CMD_NONE;
    assign c_address = fetch_pc;

`ifdef ARMLEOCPU_PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            perf_killed <= perf_killed + (clear ? 32'(count) : 32'd0) + 32'(drop);
        end
    end
`endif

endmodule

// File: tb/tb_armleocpu_prefetch.sv
// Self-checking bench for armleocpu_prefetch: cache responder plus a pc-stream model of
// what execute should receive, driven by directed scenarios and a randomized run.
module tb_armleocpu_prefetch;

    localparam logic [3:0] CMD_NONE = 4'd0;
    localparam logic [3:0] CMD_EXEC = 4'd1;
    localparam logic [3:0] R_IDLE   = 4'd0;
    localparam logic [3:0] R_WAIT   = 4'd1;
    localparam logic [3:0] R_DONE   = 4'd2;
    localparam logic [3:0] R_AF     = 4'd3;
    localparam logic [3:0] R_MA     = 4'd4;
    localparam logic [3:0] R_PF     = 4'd5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, c_reset_done;
    logic [3:0]  c_cmd, c_response;
    logic [31:0] c_address, c_load_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        f2e_valid, f2e_ready, f2e_err;
    logic [31:0] f2e_instr, f2e_pc, f2e_cause;
    logic        dbg_request, dbg_set_pc, dbg_exit_request, dbg_mode, dbg_done;
    logic [31:0] dbg_pc;
`ifdef ARMLEOCPU_PREFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_killed;
`endif

    always #5 clk = ~clk;

    armleocpu_prefetch dut (
        .clk(clk), .rst_n(rst_n), .c_reset_done(c_reset_done),
        .c_cmd(c_cmd), .c_address(c_address), .c_response(c_response), .c_load_data(c_load_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .f2e_valid(f2e_valid), .f2e_ready(f2e_ready), .f2e_instr(f2e_instr), .f2e_pc(f2e_pc),
        .f2e_err(f2e_err), .f2e_cause(f2e_cause),
        .dbg_request(dbg_request), .dbg_set_pc(dbg_set_pc), .dbg_pc(dbg_pc),
        .dbg_exit_request(dbg_exit_request), .dbg_mode(dbg_mode), .dbg_done(dbg_done)
`ifdef ARMLEOCPU_PREFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
    );

    int total = 0;
    int bad = 0;

    // cache responder state
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_wait = 0;
    logic [31:0] pf_addr = 32'hFFFF_FFFF;
    bit          rand_lat = 1'b0;

    // expected instruction stream seen by execute
    logic [31:0] exp_pc = 32'h0000_2000;
    bit          stalled = 1'b0;

    int          cyc = 0, n_exec = 0, n_pop = 0, first_exec = -1, first_valid = -1;
    logic [31:0] last_exec_addr = '0;
    logic [31:0] pop_pcs[$];
    logic [31:0] last_pop_pc, last_pop_instr, last_pop_cause;
    logic        last_pop_err;
    logic [3:0]  s_cmd;
    logic        s_valid, s_err, s_dbg_mode, s_dbg_done;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [3:0] resp_of(input logic [31:0] a);
        if (a[1:0] != 2'b00) return R_MA;
        if (a == pf_addr) return R_PF;
        if (a[9:2] == 8'hF7) return R_AF;
        return R_DONE;
    endfunction

    function automatic logic [31:0] cause_of(input logic [31:0] a);
        case (resp_of(a))
            R_AF:    return 32'd1;
            R_PF:    return 32'd12;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (pop_pcs.size() > i) ? pop_pcs[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive cache response, sample at posedge+4, update models, advance.
    task automatic cycle();
        logic resp_now;
        logic fault;
        if (!rst_n) pend = 1'b0;
        resp_now    = pend && (pend_wait == 0);
        c_response  = resp_now ? resp_of(pend_addr) : (pend ? R_WAIT : R_IDLE);
        c_load_data = resp_now ? data_of(pend_addr) : $urandom;
        #3;
        s_cmd = c_cmd; s_valid = f2e_valid; s_err = f2e_err;
        s_dbg_mode = dbg_mode; s_dbg_done = dbg_done;
        if (rst_n) begin
            if (f2e_valid && first_valid < 0) first_valid = cyc;
            if (c_cmd == CMD_EXEC) begin
                chk("single_outstanding", {31'b0, pend}, 32'd0);
                if (first_exec < 0) first_exec = cyc;
                n_exec++;
                last_exec_addr = c_address;
            end else if (c_cmd != CMD_NONE) begin
                chk("cmd_encoding", {28'b0, c_cmd}, {28'b0, CMD_NONE});
            end
            if (f2e_valid && f2e_ready && !redir_valid) begin
                fault = (resp_of(exp_pc) != R_DONE);
                chk("pop_after_fault", {31'b0, stalled}, 32'd0);
                chk("head_pc", f2e_pc, exp_pc);
                chk("head_err", {31'b0, f2e_err}, {31'b0, fault});
                chk("head_instr", f2e_instr, fault ? NOP : data_of(exp_pc));
                if (fault) chk("head_cause", f2e_cause, cause_of(exp_pc));
                pop_pcs.push_back(f2e_pc);
                last_pop_pc = f2e_pc; last_pop_instr = f2e_instr;
                last_pop_err = f2e_err; last_pop_cause = f2e_cause;
                n_pop++;
                if (fault) stalled = 1'b1;
                else exp_pc = exp_pc + 32'd4;
            end
            if (redir_valid) begin
                exp_pc  = redir_pc;
                stalled = 1'b0;
            end
            if (resp_now) pend = 1'b0;
            else if (pend) pend_wait--;
            if (c_cmd == CMD_EXEC) begin
                pend      = 1'b1;
                pend_addr = c_address;
                if (c_address == slow_addr) pend_wait = slow_wait;
                else pend_wait = rand_lat ? int'($urandom_range(2, 0)) : 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic cache_ready);
        rst_n = 1'b0; c_reset_done = cache_ready; redir_valid = 1'b0; redir_pc = '0;
        f2e_ready = 1'b0; dbg_request = 1'b0; dbg_set_pc = 1'b0; dbg_pc = '0; dbg_exit_request = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1; pend = 1'b0; exp_pc = 32'h0000_2000; stalled = 1'b0;
        first_exec = -1; first_valid = -1; n_exec = 0; n_pop = 0; pop_pcs.delete();
    endtask

    task automatic wait_exec(input int since, input int budget);
        for (int i = 0; i < budget && n_exec == since; i++) cycle();
        chk("exec_timeout", 32'(n_exec != since), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_valid = 1'b1; redir_pc = pc;
        cycle();
        redir_valid = 1'b0;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; c_reset_done = 1'b0; c_response = R_IDLE; c_load_data = '0;
        redir_valid = 1'b0; redir_pc = '0; f2e_ready = 1'b0;
        dbg_request = 1'b0; dbg_set_pc = 1'b0; dbg_pc = '0; dbg_exit_request = 1'b0;
        @(posedge clk);
        #1;

        // reset state and no command before the cache is ready
        do_reset(1'b0);
        cycle();
        chk("rst_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_cmd", {28'b0, s_cmd}, {28'b0, CMD_NONE});
        chk("rst_dbg_done", {31'b0, s_dbg_done}, 32'd0);
        chk("rst_err", {31'b0, s_err}, 32'd0);
        chk("rst_dbg_mode", {31'b0, s_dbg_mode}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("no_cmd_before_cache_ready", {28'b0, s_cmd}, {28'b0, CMD_NONE});
        end

        // sequential delivery and first-entry latency
        c_reset_done = 1'b1;
        f2e_ready = 1'b1;
        for (int i = 0; i < 30 && n_pop < 3; i++) cycle();
        chk("seq_pc0", pop_at(0), 32'h0000_2000);
        chk("seq_pc1", pop_at(1), 32'h0000_2004);
        chk("seq_pc2", pop_at(2), 32'h0000_2008);
        chk("first_valid_latency", 32'(first_valid - first_exec), 32'd2);

        // back-pressure: exactly DEPTH requests, then one per pop
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) cycle();
        chk("full_exec_count", 32'(n_exec), 32'd4);
        chk("full_cmd_none", {28'b0, s_cmd}, {28'b0, CMD_NONE});
        f2e_ready = 1'b1;
        cycle();
        f2e_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("refill_exec_count", 32'(n_exec), 32'd5);
        chk("refill_addr", last_exec_addr, 32'h0000_2010);

        // redirect with 3 queued entries and 0x2010 in flight
        do_reset(1'b1);
        slow_addr = 32'h0000_2010; slow_wait = 6;
        for (int i = 0; i < 12; i++) cycle();
        f2e_ready = 1'b1;
        cycle();
        f2e_ready = 1'b0;
        wait_exec(n_exec, 5);
        chk("inflight_addr", last_exec_addr, 32'h0000_2010);
        redirect(32'h0000_8000);
        n0 = n_exec;
        cycle();
        chk("redir_queue_empty", {31'b0, s_valid}, 32'd0);
        chk("redir_no_issue_while_killed", {28'b0, s_cmd}, {28'b0, CMD_NONE});
        wait_exec(n0, 20);
        chk("redir_exec_addr", last_exec_addr, 32'h0000_8000);
        f2e_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("redir_first_pop", pop_at(1), 32'h0000_8000);
        slow_addr = 32'hFFFF_FFFF;

        // page fault entry stalls fetch until redirect
        do_reset(1'b1);
        f2e_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        pf_addr = 32'h0000_3000;
        redirect(32'h0000_3000);
        n0 = n_pop;
        for (int i = 0; i < 20 && n_pop == n0; i++) cycle();
        chk("pf_pc", last_pop_pc, 32'h0000_3000);
        chk("pf_err", {31'b0, last_pop_err}, 32'd1);
        chk("pf_cause", last_pop_cause, 32'd12);
        chk("pf_instr", last_pop_instr, NOP);
        n0 = n_exec;
        for (int i = 0; i < 10; i++) cycle();
        chk("pf_stall_no_exec", 32'(n_exec), 32'(n0));
        redirect(32'h0000_3100);
        wait_exec(n_exec, 5);
        chk("pf_resume_addr", last_exec_addr, 32'h0000_3100);
        for (int i = 0; i < 4; i++) cycle();
        pf_addr = 32'hFFFF_FFFF;

        // debug halt with request in flight, then set_pc + exit together
        do_reset(1'b1);
        f2e_ready = 1'b1;
        slow_addr = 32'h0000_2008; slow_wait = 4;
        for (int i = 0; i < 20 && last_exec_addr != 32'h0000_2008; i++) cycle();
        chk("dbg_inflight_addr", last_exec_addr, 32'h0000_2008);
        dbg_request = 1'b1;
        cycle();
        dbg_request = 1'b0;
        n0 = n_exec;
        for (int i = 0; i < 20 && !s_dbg_mode; i++) cycle();
        chk("dbg_mode_entered", {31'b0, s_dbg_mode}, 32'd1);
        chk("dbg_done_on_entry", {31'b0, s_dbg_done}, 32'd1);
        chk("dbg_drain_no_exec", 32'(n_exec), 32'(n0));
        cycle();
        chk("dbg_done_pulse_once", {31'b0, s_dbg_done}, 32'd0);
        chk("dbg_halt_queue_empty", {31'b0, s_valid}, 32'd0);
        dbg_set_pc = 1'b1; dbg_pc = 32'h0000_4000; dbg_exit_request = 1'b1;
        cycle();
        dbg_set_pc = 1'b0; dbg_exit_request = 1'b0;
        exp_pc = 32'h0000_4000; stalled = 1'b0;
        n0 = n_exec;
        cycle();
        chk("dbg_set_pc_done", {31'b0, s_dbg_done}, 32'd1);
        chk("dbg_exit_mode", {31'b0, s_dbg_mode}, 32'd0);
        wait_exec(n0, 5);
        chk("dbg_resume_addr", last_exec_addr, 32'h0000_4000);
        for (int i = 0; i < 6; i++) cycle();
        slow_addr = 32'hFFFF_FFFF;

        // fetch_pc wraps past 0xFFFF_FFFC
        do_reset(1'b1);
        f2e_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        redirect(32'hFFFF_FFFC);
        wait_exec(n_exec, 5);
        chk("wrap_first_addr", last_exec_addr, 32'hFFFF_FFFC);
        wait_exec(n_exec, 5);
        chk("wrap_next_addr", last_exec_addr, 32'h0000_0000);
        for (int i = 0; i < 5; i++) cycle();

        // randomized run against the stream model
        do_reset(1'b1);
        rand_lat = 1'b1;
        pf_addr = 32'h0001_0040;
        for (int i = 0; i < 3; i++) cycle();
        n0 = n_pop;
        for (int i = 0; i < 800; i++) begin
            f2e_ready = ($urandom_range(3, 0) != 0);
            if ($urandom_range(24, 0) == 0) begin
                redir_valid = 1'b1;
                redir_pc = 32'h0001_0000 | ($urandom & 32'h0000_03FC);
                if ($urandom_range(7, 0) == 0) redir_pc = redir_pc | 32'd2;
            end else begin
                redir_valid = 1'b0;
            end
            cycle();
        end
        redir_valid = 1'b0;
        chk("random_progress", 32'(n_pop - n0 > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/armleocpu_prefetch.md
Name: armleocpu_prefetch

Overview:
Parametrised next-generation instruction fetch unit with a DEPTH-entry prefetch queue between the cache and execute. Issues sequential EXECUTE requests to the instruction cache ahead of consumption and buffers {pc, instr, error, cause} entries. Hands entries to execute over a valid/ready handshake. Supports redirect with queue kill and in-flight discard, and a debug halt mode. Sits between the fetch-side cache port and armleocpu_execute.

Parameters:
RESET_VECTOR, 32'h0000_2000, first fetch address after reset
DEPTH, 4, queue entries; power of two, >= 2
CAUSE_W, 32, width of exception cause field

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
c_reset_done  in  1  cache finished its own reset
c_cmd  out  4  cache command (CACHE_CMD_NONE / CACHE_CMD_EXECUTE)
c_address  out  32  fetch address, valid while c_cmd = EXECUTE
c_response  in  4  CACHE_RESPONSE_IDLE/WAIT/DONE/ACCESSFAULT/MISSALIGNED/PAGEFAULT
c_load_data  in  32  instruction word, valid with DONE
redir_valid  in  1  execute redirect (branch, exception, xRET, flush)
redir_pc  in  32  redirect target
f2e_valid  out  1  queue head valid
f2e_ready  in  1  execute accepts head
f2e_instr  out  32  head instruction (NOP 32'h0000_0013 when f2e_err)
f2e_pc  out  32  head pc
f2e_err  out  1  head is a fetch fault
f2e_cause  out  CAUSE_W  EXCEPTION_CODE_INSTRUCTION_* for fault
dbg_request  in  1  enter debug halt
dbg_set_pc  in  1  load dbg_pc while halted
dbg_pc  in  32  debug pc
dbg_exit_request  in  1  leave debug halt
dbg_mode  out  1  halted
dbg_done  out  1  one-cycle pulse: halt entered or set_pc applied

Behaviour:
- Reset (rst_n=0 at posedge): state=WAIT_CACHE, fetch_pc=RESET_VECTOR, queue empty, outstanding=0, kill=0, dbg_mode=0. Outputs: f2e_valid=0, c_cmd=NONE, dbg_done=0, f2e_err=0. Reset mid-request abandons the request; the cache is reset in the same cycle.
- States: WAIT_CACHE, RUN, FAULT_STALL, HALT_DRAIN, HALT.
- WAIT_CACHE -> RUN when c_reset_done=1. No command is issued before then.
- One outstanding request maximum. Issue rule in RUN: c_cmd=EXECUTE, c_address=fetch_pc when outstanding=0 and count < DEPTH and redir_valid=0. Outstanding is set the same cycle.
- Response while outstanding, kill=0:
  - DONE: push {fetch_pc, c_load_data, 0}; fetch_pc += 4, wraps modulo 2^32.
  - Fault: push {fetch_pc, NOP, 1, cause} with MISSALIGNED->0, ACCESSFAULT->1, PAGEFAULT->12; go to FAULT_STALL.
  - A new request may be issued in the cycle after the response, never the same cycle.
- Free space is reserved at issue, so a push never hits a full queue. Simultaneous push+pop keeps count unchanged. Pop when f2e_valid & f2e_ready.
- Head outputs come combinationally from the queue head. f2e_valid = (count != 0). Earliest latency is EXECUTE at cycle N, DONE at N+1, f2e_valid at N+2.
- redir_valid (any state except WAIT_CACHE/HALT):
  - Queue cleared next cycle; a pop in the same cycle is ignored.
  - fetch_pc=redir_pc; FAULT_STALL -> RUN.
  - If a request is outstanding, kill=1. Its response (DONE or fault) is dropped, then outstanding=0, kill=0.
  - redir_valid has priority over dbg_request.
- dbg_request in RUN/FAULT_STALL -> HALT_DRAIN: no new issue; wait outstanding=0 (response dropped). Then clear queue -> HALT, dbg_mode=1, dbg_done pulse.
- HALT: dbg_set_pc -> fetch_pc=dbg_pc, dbg_done pulse. dbg_exit_request -> RUN, dbg_mode=0 next cycle. set_pc and exit in the same cycle: both apply.
- WAIT/IDLE responses with no outstanding request are ignored.

Optional Feature:
ARMLEOCPU_PREFETCH_PERF_EN: adds outputs perf_fetched (32) and perf_killed (32).
- perf_fetched increments per pushed entry.
- perf_killed adds the number of entries cleared, plus 1 per dropped in-flight response.
- Both counters reset to 0 and wrap.
Without the macro: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, c_reset_done=1, cache DONE after 1 cycle, f2e_ready=1 -> pcs 0x2000,0x2004,0x2008 delivered in order, first f2e_valid 2 cycles after first EXECUTE.
- f2e_ready=0, DEPTH=4 -> exactly 4 EXECUTEs issued, then c_cmd=NONE; one pop -> exactly one new EXECUTE.
- redir_valid, redir_pc=0x8000 while request to 0x2010 outstanding and 3 entries queued -> queue empty, 0x2010 data dropped, next EXECUTE c_address=0x8000.
- Response PAGEFAULT at 0x3000 -> entry f2e_err=1, f2e_cause=12, f2e_instr=0x00000013; no further EXECUTE until redir_valid.
- dbg_request with request outstanding -> no new issue, dbg_mode=1 and dbg_done after DONE; dbg_set_pc 0x4000 + dbg_exit_request -> next EXECUTE at 0x4000.
- fetch_pc=0xFFFF_FFFC DONE -> next c_address=0x0000_0000.
